// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: 8N1 UART transmitter fed by a small byte FIFO, LSB first, back-to-back frames
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 4,
  parameter int FIFO_AW      = 2
) (
  input  logic               clk,
  input  logic               nRst,
  input  logic [7:0]         in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic               tx,
  output logic               busy,
  output logic [FIFO_AW:0]   level
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [FIFO_AW:0] FULL = (FIFO_AW+1)'(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state_q, state_d;
  logic [7:0] mem_q [FIFO_DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [FIFO_AW:0] level_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] shift_q, shift_d;
  logic tx_q, tx_d, push, pop, wrap, has_data;
  assign in_ready = level_q != FULL;
  assign push = in_valid && in_ready;
  assign has_data = level_q != '0;
  assign wrap = cnt_q == CW'(CLKS_PER_BIT-1);
  assign tx = tx_q;
  assign busy = state_q != IDLE;
  assign level = level_q;
  always_comb begin
    state_d = state_q;
    cnt_d = wrap ? '0 : cnt_q + 1'b1;
    idx_d = idx_q;
    shift_d = shift_q;
    tx_d = tx_q;
    pop = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        tx_d = 1'b1;
        if (has_data) begin
          pop = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          tx_d = 1'b0;
          state_d = START;
        end
      end
      START: if (wrap) begin
        tx_d = shift_q[0];
        idx_d = '0;
        state_d = DATA;
      end
      DATA: if (wrap) begin
        if (idx_q == 3'd7) begin
          tx_d = 1'b1;
          state_d = STOP;
        end else begin
          shift_d = shift_q >> 1;
          tx_d = shift_q[1];
          idx_d = idx_q + 3'd1;
        end
      end
      STOP: if (wrap) begin
        // a queued byte starts its frame on this very edge, leaving no idle gap
        if (has_data) begin
          pop = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          tx_d = 1'b0;
          state_d = START;
        end else begin
          tx_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (nRst) begin
      state_q <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q <= '0;
      cnt_q <= '0;
      idx_q <= '0;
      shift_q <= '0;
      tx_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      shift_q <= shift_d;
      tx_q <= tx_d;
      wr_ptr_q <= push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_q <= pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
      level_q <= (push && !pop) ? level_q + 1'b1 : (!push && pop) ? level_q - 1'b1 : level_q;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: frame-level model of the transmitter checked every cycle, plus literal frame checks
module tb_uart_tx_fifo;
  localparam int CPB = 4;
  logic clk = 1'b0, nRst = 1'b1;
  logic [7:0] in_data = '0, in_data2 = '0;
  logic in_valid = 1'b0, in_valid2 = 1'b0;
  logic in_ready, tx, busy, in_ready2, tx2, busy2;
  logic [2:0] level, level2;
  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4), .FIFO_AW(2)) dut (
    .clk(clk), .nRst(nRst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .tx(tx), .busy(busy), .level(level));
  uart_tx_fifo dut434 (
    .clk(clk), .nRst(nRst), .in_data(in_data2), .in_valid(in_valid2),
    .in_ready(in_ready2), .tx(tx2), .busy(busy2), .level(level2));
  always #10 clk = ~clk;
  int n_cmp = 0, n_fail = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // model: a queue of accepted bytes and the age of the frame on the wire
  logic [7:0] mq[$];
  bit m_busy = 0, acc, chk_en = 0;
  int m_el = 0;
  logic [7:0] m_byte = '0;
  function automatic logic m_tx();
    int b;
    if (!m_busy) return 1'b1;
    b = m_el / CPB;
    if (b == 0) return 1'b0;
    if (b <= 8) return m_byte[b-1];
    return 1'b1;
  endfunction
  always @(posedge clk) begin
    if (nRst) begin
      mq.delete();
      m_busy = 0;
      m_el = 0;
    end else begin
      acc = in_valid && mq.size() < 4;
      if (m_busy && m_el + 1 < 10*CPB) m_el++;
      else if (mq.size() > 0) begin
        m_byte = mq.pop_front();
        m_busy = 1;
        m_el = 0;
      end else m_busy = 0;
      if (acc) mq.push_back(in_data);
    end
  end
  always @(negedge clk) if (chk_en) begin
    chk("tx", tx, m_tx());
    chk("busy", busy, m_busy);
    chk("level", level, mq.size());
    chk("in_ready", in_ready, mq.size() != 4);
  end
  // line receiver sampling mid-bit, used for the literal frame checks
  int rc = -1, cyc = 0;
  logic [9:0] rf = '0;
  logic [7:0] rx_q[$];
  logic [9:0] rxf_q[$];
  int st_q[$];
  always @(negedge clk) begin
    cyc++;
    if (rc < 0) begin
      if (tx === 1'b0) begin
        rc = 0;
        st_q.push_back(cyc);
      end
    end else rc++;
    if (rc >= 0 && rc % CPB == CPB/2) rf[rc/CPB] = tx;
    if (rc == 10*CPB - CPB/2) begin
      rx_q.push_back(rf[8:1]);
      rxf_q.push_back(rf);
      rc = -1;
    end
  end
  task automatic clear_rx();
    rx_q.delete();
    rxf_q.delete();
    st_q.delete();
  endtask
  task automatic push(input logic [7:0] b, input int exp_lvl);
    int n = 0;
    in_valid = 1'b1;
    while (!in_ready && n < 2000) begin
      in_data = 8'($urandom);
      @(negedge clk);
      n++;
    end
    chk("push_timeout", n < 2000, 1);
    in_data = b;
    @(negedge clk);
    in_valid = 1'b0;
    if (exp_lvl >= 0) chk("push_level", level, exp_lvl);
  endtask
  task automatic wait_rx(input int n);
    int k = 0;
    while (rx_q.size() < n && k < 3000) begin
      @(negedge clk);
      k++;
    end
    chk("rx_count", rx_q.size() >= n, 1);
  endtask
  initial begin
    int lv[6] = '{1, 1, 2, 3, 4, 4};
    longint t0, t1, dt;
    int k;
    logic [9:0] f6;
    repeat (3) @(negedge clk);
    chk("rst_tx", tx, 1);
    chk("rst_level", level, 0);
    nRst = 1'b0;
    chk_en = 1;
    // single byte A5
    push(8'hA5, 1);
    @(negedge clk);
    chk("a5_level_after", level, 0);
    wait_rx(1);
    if (rxf_q.size() > 0) chk("a5_frame", rxf_q[0], 10'b1101001010);
    repeat (4) @(negedge clk);
    chk("a5_busy_end", busy, 0);
    chk("a5_tx_end", tx, 1);
    clear_rx();
    // reset held 3 cycles in the middle of traffic
    push(8'h55, 1);
    push(8'h66, 1);
    repeat (10) @(negedge clk);
    nRst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_mid_tx", tx, 1);
    chk("rst_mid_ready", in_ready, 1);
    chk("rst_mid_level", level, 0);
    chk("rst_mid_busy", busy, 0);
    nRst = 1'b0;
    repeat (50) @(negedge clk);
    clear_rx();
    // four bytes on consecutive edges
    push(8'h80, 1);
    push(8'h01, 1);
    push(8'hAA, 2);
    push(8'h81, 3);
    wait_rx(4);
    if (rx_q.size() >= 4) begin
      chk("b2b_0", rx_q[0], 8'h80);
      chk("b2b_1", rx_q[1], 8'h01);
      chk("b2b_2", rx_q[2], 8'hAA);
      chk("b2b_3", rx_q[3], 8'h81);
      chk("b2b_gap1", st_q[1] - st_q[0], 40);
      chk("b2b_gap2", st_q[2] - st_q[1], 40);
      chk("b2b_total", st_q[3] - st_q[0] + 40, 160);
    end
    repeat (6) @(negedge clk);
    chk("b2b_busy_end", busy, 0);
    clear_rx();
    // overflow with in_valid held
    for (int i = 0; i < 6; i++) begin
      push(8'h10 + 8'(i), lv[i]);
      if (i == 4) chk("full_ready", in_ready, 0);
    end
    wait_rx(6);
    repeat (50) @(negedge clk);
    chk("ovf_count", rx_q.size(), 6);
    for (int i = 0; i < 6 && i < rx_q.size(); i++) chk("ovf_byte", rx_q[i], 8'h10 + 8'(i));
    clear_rx();
    // reset during data bit 3 of FF with two bytes queued
    push(8'hFF, 1);
    push(8'h11, 1);
    push(8'h22, 2);
    repeat (16) @(negedge clk);
    nRst = 1'b1;
    @(negedge clk);
    chk("rst_d3_tx", tx, 1);
    chk("rst_d3_level", level, 0);
    chk("rst_d3_busy", busy, 0);
    nRst = 1'b0;
    repeat (50) @(negedge clk);
    clear_rx();
    push(8'h3C, 1);
    wait_rx(1);
    if (rxf_q.size() > 0) chk("3c_frame", rxf_q[0], 10'b1001111000);
    repeat (50) @(negedge clk);
    chk("3c_only", rx_q.size(), 1);
    // default baud: 434 clocks of 20 ns per bit
    in_data2 = 8'h81;
    in_valid2 = 1'b1;
    @(negedge clk);
    in_valid2 = 1'b0;
    k = 0;
    while (tx2 !== 1'b0 && k < 100) begin @(negedge clk); k++; end
    chk("baud_start_seen", k < 100, 1);
    t0 = $time;
    k = 0;
    while (tx2 !== 1'b1 && k < 1000) begin @(negedge clk); k++; end
    t1 = $time;
    dt = t1 - t0;
    n_cmp++;
    if (dt < 8660 || dt > 8700) begin
      n_fail++;
      $display("FAIL bit_period: got %0d ns expected 8680 +/- 20 ns", dt);
    end
    f6 = '0;
    f6[0] = 1'b0;
    repeat (217) @(negedge clk);
    f6[1] = tx2;
    for (int b = 2; b < 10; b++) begin
      repeat (434) @(negedge clk);
      f6[b] = tx2;
    end
    chk("baud_byte", f6[8:1], 8'h81);
    chk("baud_stop", f6[9], 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
